// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for a 5-stage in-order pipeline.
//
// Decides, every cycle, which pipeline registers load and which get a bubble.
// Priority order: watchdog halt, memory stall, redirect, load-use, normal.
// Also selects the EX-stage operand forwarding sources, runs a memory-stall
// watchdog that halts the pipe for good, and keeps optional performance
// counters.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the three performance
// counters. Without it, perf_* are tied to zero and no counter flops exist.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   id_rs, id_rs_used         ID source registers (NSRC x RA_W) and valid flags
//   ex_rs, ex_rs_used         EX source registers and valid flags
//   ex_valid/ex_we/ex_is_load/ex_rd   EX instruction info
//   mem_valid/mem_we/mem_rd   MEM instruction info
//   wb_valid/wb_we/wb_rd      WB instruction info
//   redirect                  taken branch/jump resolved in MEM
//   inst_read, inst_resp      instruction memory handshake
//   data_req, data_resp       data memory handshake
//   ld_*                      load enables for PC and stage registers
//   flush_*                   bubble insertion for stage registers
//   fwd_sel                   per EX source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   timeout                   sticky watchdog flag
//   perf_stall/flush/lu       performance counters (32 bit, wrapping)
module pipe_ctrl #(
    parameter int RA_W = 5,
    parameter int NSRC = 2,
    parameter int WD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC*RA_W-1:0] id_rs,
    input  logic [NSRC-1:0]      id_rs_used,
    input  logic [NSRC*RA_W-1:0] ex_rs,
    input  logic [NSRC-1:0]      ex_rs_used,
    input  logic                 ex_valid,
    input  logic                 ex_we,
    input  logic                 ex_is_load,
    input  logic [RA_W-1:0]      ex_rd,
    input  logic                 mem_valid,
    input  logic                 mem_we,
    input  logic [RA_W-1:0]      mem_rd,
    input  logic                 wb_valid,
    input  logic                 wb_we,
    input  logic [RA_W-1:0]      wb_rd,
    input  logic                 redirect,
    input  logic                 inst_read,
    input  logic                 inst_resp,
    input  logic                 data_req,
    input  logic                 data_resp,
    output logic                 ld_pc,
    output logic                 ld_if_id,
    output logic                 ld_id_ex,
    output logic                 ld_ex_mem,
    output logic                 ld_mem_wb,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 flush_ex_mem,
    output logic [2*NSRC-1:0]    fwd_sel,
    output logic                 timeout,
    output logic [31:0]          perf_stall,
    output logic [31:0]          perf_flush,
    output logic [31:0]          perf_lu
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    localparam logic [WD_W-1:0] WD_MAX = '1;

    state_t          state, state_nxt;
    logic [WD_W-1:0] wd, wd_nxt;
    logic            mem_stall;
    logic            lu_hit;
    logic            load_use;
    logic            halted;
    logic            redir_act;
    logic            lu_act;

    assign mem_stall = (inst_read & ~inst_resp) | (data_req & ~data_resp);
    assign halted    = (state == HALT);

    always_comb begin
        lu_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_rs_used[i] && (id_rs[i*RA_W +: RA_W] == ex_rd))
                lu_hit = 1'b1;
        end
    end

    assign load_use = ex_valid & ex_is_load & ex_we & (ex_rd != '0) & lu_hit;

    // Qualified events after priority resolution; rst gates them so that
    // nothing is reported while reset is held.
    assign redir_act = rst & ~halted & ~mem_stall & redirect;
    assign lu_act    = rst & ~halted & ~mem_stall & ~redirect & load_use;

    // Watchdog counts consecutive stall cycles and saturates at its maximum.
    always_comb begin
        wd_nxt = '0;
        if (mem_stall)
            wd_nxt = (wd == WD_MAX) ? wd : wd + WD_W'(1);
    end

    // Halt is taken on the edge where the watchdog reaches its maximum.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (wd_nxt == WD_MAX)
                    state_nxt = HALT;
                else if (mem_stall)
                    state_nxt = MEMWAIT;
            end
            MEMWAIT: begin
                if (wd_nxt == WD_MAX)
                    state_nxt = HALT;
                else if (!mem_stall)
                    state_nxt = RUN;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            wd      <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            wd      <= wd_nxt;
            timeout <= timeout | halted;
        end
    end

    // Stage control and forwarding; everything is forced low under reset.
    always_comb begin
        ld_pc        = 1'b0;
        ld_if_id     = 1'b0;
        ld_id_ex     = 1'b0;
        ld_ex_mem    = 1'b0;
        ld_mem_wb    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        fwd_sel      = '0;
        if (rst) begin
            if (redir_act) begin
                ld_pc        = 1'b1;
                ld_if_id     = 1'b1;
                ld_id_ex     = 1'b1;
                ld_ex_mem    = 1'b1;
                ld_mem_wb    = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (lu_act) begin
                // Hold PC and IF/ID, let the load advance, bubble into EX.
                ld_id_ex     = 1'b1;
                ld_ex_mem    = 1'b1;
                ld_mem_wb    = 1'b1;
                flush_id_ex  = 1'b1;
            end else if (!halted && !mem_stall) begin
                ld_pc        = 1'b1;
                ld_if_id     = 1'b1;
                ld_id_ex     = 1'b1;
                ld_ex_mem    = 1'b1;
                ld_mem_wb    = 1'b1;
            end
            for (int i = 0; i < NSRC; i++) begin
                if (ex_rs_used[i] && (ex_rs[i*RA_W +: RA_W] != '0)) begin
                    if (mem_valid && mem_we && (mem_rd == ex_rs[i*RA_W +: RA_W]))
                        fwd_sel[2*i +: 2] = 2'b01;
                    else if (wb_valid && wb_we && (wb_rd == ex_rs[i*RA_W +: RA_W]))
                        fwd_sel[2*i +: 2] = 2'b10;
                end
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
            perf_lu    <= '0;
        end else if (!halted) begin
            if (mem_stall)
                perf_stall <= perf_stall + 32'd1;
            if (redir_act)
                perf_flush <= perf_flush + 32'd1;
            if (lu_act)
                perf_lu    <= perf_lu + 32'd1;
        end
    end
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
    assign perf_lu    = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios, a behavioural reference model
// checked every cycle on the falling edge, plus hand-computed literal checks.
module tb_pipe_ctrl;

    localparam int RA_W  = 5;
    localparam int NSRC  = 2;
    localparam int WD_W  = 4;
    localparam int WDMAX = (1 << WD_W) - 1;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [7:0] CTL_OFF  = 8'b00000_000;
    localparam logic [7:0] CTL_NORM = 8'b11111_000;
    localparam logic [7:0] CTL_RED  = 8'b11111_111;
    localparam logic [7:0] CTL_LU   = 8'b00111_010;

    logic                 clk;
    logic                 rst;
    logic [NSRC*RA_W-1:0] id_rs;
    logic [NSRC-1:0]      id_rs_used;
    logic [NSRC*RA_W-1:0] ex_rs;
    logic [NSRC-1:0]      ex_rs_used;
    logic                 ex_valid, ex_we, ex_is_load;
    logic [RA_W-1:0]      ex_rd;
    logic                 mem_valid, mem_we;
    logic [RA_W-1:0]      mem_rd;
    logic                 wb_valid, wb_we;
    logic [RA_W-1:0]      wb_rd;
    logic                 redirect, inst_read, inst_resp, data_req, data_resp;
    logic                 ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb;
    logic                 flush_if_id, flush_id_ex, flush_ex_mem;
    logic [2*NSRC-1:0]    fwd_sel;
    logic                 timeout;
    logic [31:0]          perf_stall, perf_flush, perf_lu;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.RA_W(RA_W), .NSRC(NSRC), .WD_W(WD_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_rs(ex_rs), .ex_rs_used(ex_rs_used),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .redirect(redirect),
        .inst_read(inst_read), .inst_resp(inst_resp),
        .data_req(data_req), .data_resp(data_resp),
        .ld_pc(ld_pc), .ld_if_id(ld_if_id), .ld_id_ex(ld_id_ex),
        .ld_ex_mem(ld_ex_mem), .ld_mem_wb(ld_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .fwd_sel(fwd_sel), .timeout(timeout),
        .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_lu(perf_lu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctl();
        return {ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb,
                flush_if_id, flush_id_ex, flush_ex_mem};
    endfunction

    // ---------------- reference model ----------------
    int          m_run;      // consecutive stall cycles seen, saturating
    bit          m_halt;
    bit          m_timeout;
    logic [31:0] m_pstall, m_pflush, m_plu;

    function automatic bit stall_now();
        return (inst_read && !inst_resp) || (data_req && !data_resp);
    endfunction

    function automatic bit lu_now();
        bit hit = 1'b0;
        for (int i = 0; i < NSRC; i++)
            if (id_rs_used[i] && id_rs[i*RA_W +: RA_W] == ex_rd) hit = 1'b1;
        return ex_valid && ex_we && ex_is_load && (ex_rd != 0) && hit;
    endfunction

    function automatic logic [7:0] exp_ctl();
        if (!rst || m_halt || stall_now()) return CTL_OFF;
        if (redirect) return CTL_RED;
        if (lu_now()) return CTL_LU;
        return CTL_NORM;
    endfunction

    function automatic logic [2*NSRC-1:0] exp_fwd();
        logic [2*NSRC-1:0] r = '0;
        for (int i = 0; i < NSRC; i++) begin
            logic [RA_W-1:0] s = ex_rs[i*RA_W +: RA_W];
            if (rst && ex_rs_used[i] && s != 0) begin
                if (mem_valid && mem_we && mem_rd == s)    r[2*i +: 2] = 2'b01;
                else if (wb_valid && wb_we && wb_rd == s)  r[2*i +: 2] = 2'b10;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run     <= 0;
            m_halt    <= 1'b0;
            m_timeout <= 1'b0;
            m_pstall  <= '0;
            m_pflush  <= '0;
            m_plu     <= '0;
        end else begin
            m_timeout <= m_timeout | m_halt;
            if (stall_now()) begin
                m_run <= (m_run < WDMAX) ? m_run + 1 : m_run;
                if (m_run + 1 >= WDMAX) m_halt <= 1'b1;
            end else begin
                m_run <= 0;
            end
            if (PERF && !m_halt) begin
                if (stall_now())     m_pstall <= m_pstall + 1;
                else if (redirect)   m_pflush <= m_pflush + 1;
                else if (lu_now())   m_plu    <= m_plu + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("ctl", {24'd0, ctl()}, {24'd0, exp_ctl()});
        chk("fwd_sel", {28'd0, fwd_sel}, {28'd0, exp_fwd()});
        chk("timeout", {31'd0, timeout}, {31'd0, m_timeout});
        chk("perf_stall", perf_stall, m_pstall);
        chk("perf_flush", perf_flush, m_pflush);
        chk("perf_lu", perf_lu, m_plu);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rs_used = '0; ex_rs = '0; ex_rs_used = '0;
        ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_rd = '0;
        mem_valid = 0; mem_we = 0; mem_rd = '0;
        wb_valid = 0; wb_we = 0; wb_rd = '0;
        redirect = 0; inst_read = 0; inst_resp = 0; data_req = 0; data_resp = 0;
    endtask

    task automatic set_load(input logic [RA_W-1:0] rd);
        ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rd = rd;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        repeat (3) tick();
        #1 chk("reset_ctl", {24'd0, ctl()}, {24'd0, CTL_OFF});

        rst = 1'b1;
        #1 chk("normal_ctl", {24'd0, ctl()}, {24'd0, CTL_NORM});
        tick();

        // load-use on source 0
        set_load(5'd5); id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01;
        #1 chk("lu_ld_pc", {31'd0, ld_pc}, 32'd0);
        chk("lu_flush_id_ex", {31'd0, flush_id_ex}, 32'd1);
        tick();
        id_rs_used = 2'b00;                                   // source unused
        #1 chk("lu_unused_ld_pc", {31'd0, ld_pc}, 32'd1);
        tick();
        id_rs = {5'd5, 5'd9}; id_rs_used = 2'b10;             // match on source 1
        #1 chk("lu_src1_ctl", {24'd0, ctl()}, {24'd0, CTL_LU});
        tick();
        ex_rd = 5'd0; id_rs = '0; id_rs_used = 2'b11;         // r0 never hazards
        #1 chk("lu_r0_ctl", {24'd0, ctl()}, {24'd0, CTL_NORM});
        tick();
        idle();
        #1 chk("lu_count", perf_lu, PERF ? 32'd2 : 32'd0);

        // forwarding
        mem_valid = 1; mem_we = 1; mem_rd = 5'd7;
        wb_valid = 1; wb_we = 1; wb_rd = 5'd7;
        ex_rs = {5'd7, 5'd3}; ex_rs_used = 2'b11;
        #1 chk("fwd_mem_prio", {28'd0, fwd_sel}, 32'b0100);
        tick();
        ex_rs = {5'd0, 5'd3};
        #1 chk("fwd_r0", {28'd0, fwd_sel}, 32'b0000);
        tick();
        mem_we = 0; ex_rs = {5'd7, 5'd7};
        #1 chk("fwd_wb", {28'd0, fwd_sel}, 32'b1010);
        tick();
        ex_rs_used = 2'b01;
        #1 chk("fwd_unused", {28'd0, fwd_sel}, 32'b0010);
        tick();
        idle();

        // redirect beats load-use
        set_load(5'd5); id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01; redirect = 1;
        #1 chk("redir_ctl", {24'd0, ctl()}, {24'd0, CTL_RED});
        tick();
        idle();
        #1 chk("redir_lu_cnt", perf_lu, PERF ? 32'd2 : 32'd0);
        chk("redir_flush_cnt", perf_flush, PERF ? 32'd1 : 32'd0);

        // data stall for three cycles, redirect pending underneath
        data_req = 1; data_resp = 0; redirect = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("dstall_ctl", {24'd0, ctl()}, {24'd0, CTL_OFF});
            tick();
        end
        data_resp = 1; redirect = 0;
        #1 chk("dstall_done_ctl", {24'd0, ctl()}, {24'd0, CTL_NORM});
        chk("dstall_cnt", perf_stall, PERF ? 32'd3 : 32'd0);
        tick();
        idle();

        // asynchronous reset in the middle of a stall
        data_req = 1; data_resp = 0;
        mem_valid = 1; mem_we = 1; mem_rd = 5'd7; ex_rs = {5'd0, 5'd7}; ex_rs_used = 2'b01;
        tick();
        tick();
        #1 chk("pre_rst_fwd", {28'd0, fwd_sel}, 32'b0001);
        chk("pre_rst_stall_cnt", perf_stall, PERF ? 32'd5 : 32'd0);
        rst = 1'b0;
        #1 chk("async_rst_fwd", {28'd0, fwd_sel}, 32'd0);
        chk("async_rst_cnt", perf_stall, 32'd0);
        data_resp = 1;
        #1 chk("async_rst_ctl", {24'd0, ctl()}, {24'd0, CTL_OFF});
        tick();

        // watchdog from a fresh reset: 15 stall cycles then halt
        idle();
        inst_read = 1; inst_resp = 0;
        rst = 1'b1;
        repeat (WDMAX) tick();
        #1 chk("halt_entry_timeout", {31'd0, timeout}, 32'd0);
        tick();
        #1 chk("timeout_rise", {31'd0, timeout}, 32'd1);
        chk("wd_stall_cnt", perf_stall, PERF ? 32'd15 : 32'd0);
        inst_resp = 1;
        #1 chk("halt_ctl", {24'd0, ctl()}, {24'd0, CTL_OFF});
        tick();
        #1 chk("timeout_sticky", {31'd0, timeout}, 32'd1);
        tick();

        rst = 1'b0;
        #1 chk("rst_timeout", {31'd0, timeout}, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have the parameter RA_W, default 5, giving the register address width.
REQ-002 The block SHALL have the parameter NSRC, default 2, giving the number of source operands checked per instruction (legal range 1..3).
REQ-003 The block SHALL have the parameter WD_W, default 8, giving the width of the memory-stall watchdog counter.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock. One clock domain; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_rs  in  NSRC*RA_W  source register addresses of the instruction in ID.
- id_rs_used  in  NSRC  per-source valid flags for ID.
- ex_rs  in  NSRC*RA_W  source register addresses of the instruction in EX.
- ex_rs_used  in  NSRC  per-source valid flags for EX.
- ex_valid, ex_we, ex_is_load  in  1 each  EX-stage instruction is valid, writes rd, and is a load.
- ex_rd  in  RA_W  EX-stage destination register.
- mem_valid, mem_we  in  1 each  MEM-stage instruction is valid and writes rd.
- mem_rd  in  RA_W  MEM-stage destination register.
- wb_valid, wb_we  in  1 each  WB-stage instruction is valid and writes rd.
- wb_rd  in  RA_W  WB-stage destination register.
- redirect  in  1  taken branch or jump resolved in MEM.
- inst_read, inst_resp  in  1 each  instruction memory request and response.
- data_req, data_resp  in  1 each  data memory request (read or write) and response.
- ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb  out  1 each  load enables for the PC and the stage registers.
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  insert a bubble (clear control word) into that stage register.
- fwd_sel  out  2*NSRC  per EX source: 00 regfile, 01 EX/MEM alu_out, 10 MEM/WB writeback value.
- timeout  out  1  sticky watchdog flag.
- perf_stall, perf_flush, perf_lu  out  32 each  performance counters.

Function
REQ-005 The block SHALL compute mem_stall = (inst_read & ~inst_resp) | (data_req & ~data_resp).
REQ-006 The block SHALL define load_use as ex_valid & ex_is_load & ex_we & (ex_rd != 0) & (ex_rd equal to some id_rs[i] whose id_rs_used[i] is set).
REQ-007 The FSM SHALL have three states: RUN, MEMWAIT, HALT.
- RUN -> MEMWAIT when mem_stall.
- MEMWAIT -> RUN when ~mem_stall.
- RUN or MEMWAIT -> HALT when the watchdog reaches 2^WD_W-1.
- HALT is left only by reset.
REQ-008 The watchdog SHALL count consecutive cycles in which mem_stall is set, clear to 0 on any cycle without mem_stall, and saturate at its maximum value.
REQ-009 The stall/flush priority SHALL be HALT > mem_stall > redirect > load_use > normal.
REQ-010 In HALT, or in any cycle with mem_stall, all ld_* and all flush_* outputs SHALL be 0.
REQ-011 On redirect (with no mem_stall), all ld_* outputs SHALL be 1 and flush_if_id, flush_id_ex and flush_ex_mem SHALL be 1.
- A simultaneous load_use SHALL be ignored.
REQ-012 On load_use (with no redirect and no mem_stall):
- ld_pc=0, ld_if_id=0, ld_id_ex=1, flush_id_ex=1, ld_ex_mem=1, ld_mem_wb=1.
- This produces exactly one bubble.
REQ-013 In normal operation, all ld_* outputs SHALL be 1 and all flush_* outputs SHALL be 0.
REQ-014 For each EX source i, fwd_sel[i] SHALL be chosen as follows:
- 00 if ~ex_rs_used[i] or ex_rs[i]==0;
- else 01 if mem_valid & mem_we & mem_rd==ex_rs[i];
- else 10 if wb_valid & wb_we & wb_rd==ex_rs[i];
- else 00.
- The MEM match takes priority over the WB match.
REQ-015 fwd_sel and the ld_*/flush_* outputs SHALL be combinational (zero latency); the FSM, watchdog, timeout and counters SHALL be registered.
REQ-016 timeout SHALL rise in the cycle after the block enters HALT and remain 1 until reset.

Reset
REQ-017 While rst is low, the block SHALL be held as follows:
- FSM = RUN, watchdog = 0, timeout = 0, counters = 0;
- all ld_*, flush_* and fwd_sel outputs forced to 0.
REQ-018 Deassertion of rst SHALL take effect at the next rising clk edge; assertion of rst in the middle of a stall SHALL abort the stall immediately.

Configuration
REQ-019 With PIPE_CTRL_PERF_EN defined, the performance counters SHALL operate as follows:
- perf_stall increments on each mem_stall cycle.
- perf_flush increments on each redirect flush.
- perf_lu increments on each load_use bubble.
- All three wrap modulo 2^32 and never increment in HALT.
REQ-020 Without PIPE_CTRL_PERF_EN, perf_stall, perf_flush and perf_lu SHALL be tied to 0 and no counter flops SHALL be synthesised.

Verification
REQ-021 Scenario: ex_is_load=1, ex_rd=5, id_rs[0]=5 -> one cycle with ld_pc=0 and flush_id_ex=1; perf_lu=1 (with the macro).
REQ-022 Scenario: mem_rd=wb_rd=7 with both writing, ex_rs[1]=7 -> fwd_sel[1]=01; the same case with ex_rs[1]=0 -> fwd_sel[1]=00.
REQ-023 Scenario: redirect=1 and load_use=1 in the same cycle -> three flushes, ld_pc=1, no bubble counted.
REQ-024 Scenario: data_req=1 with data_resp low for 3 cycles -> all ld_*=0 for 3 cycles; perf_stall=3; on the 4th cycle data_resp=1 -> normal operation.
REQ-025 Scenario: WD_W=4 and inst_resp held low -> HALT after 15 stall cycles, timeout=1 the next cycle, remains 1 after inst_resp rises.
REQ-026 Scenario: rst driven low mid-MEMWAIT -> all outputs 0 asynchronously; after release the FSM is in RUN and the watchdog is 0.
